// File: rtl/wbc_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : wbc_rr_arbiter                                                    |
// | Brief  : Round-robin arbiter sharing one classic Wishbone slave port       |
// |          between NM masters; grant is held for the whole bus cycle.        |
// |          Optional slave-hang timeout enabled by macro WBC_ARB_TIMEOUT_EN.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module wbc_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NM-1:0]           i_mcyc,
    input  logic [NM-1:0]           i_mstb,
    input  logic [NM-1:0]           i_mwe,
    input  logic [NM*AW-1:0]        i_maddr,
    input  logic [NM*DW-1:0]        i_mdata,
    input  logic [NM*(DW/8)-1:0]    i_msel,
    output logic [NM-1:0]           o_mack,
    output logic [NM-1:0]           o_merr,
    output logic [NM*DW-1:0]        o_mdata,
    output logic                    o_scyc,
    output logic                    o_sstb,
    output logic                    o_swe,
    output logic [AW-1:0]           o_saddr,
    output logic [DW-1:0]           o_sdata,
    output logic [(DW/8)-1:0]       o_ssel,
    input  logic                    i_sack,
    input  logic                    i_serr,
    input  logic [DW-1:0]           i_sdata,
    output logic [NM-1:0]           o_grant
);

    localparam int         c_SW      = DW / 8;
    localparam int         c_PW      = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    logic [0:0]      r_state;
    logic [NM-1:0]   r_grant;
    logic [c_PW-1:0] r_gidx;
    logic [c_PW-1:0] r_ptr;

    logic [NM-1:0]   w_req;
    logic            w_any;
    logic [c_PW-1:0] w_next_idx;
    logic            w_busy;
    logic            w_gcyc;
    logic            w_gstb;
    logic            w_tfire;

    assign w_req  = i_mcyc & i_mstb;
    assign w_busy = (r_state == c_ST_BUSY);
    assign w_gcyc = w_busy & i_mcyc[r_gidx];
    assign w_gstb = w_busy & i_mstb[r_gidx];

    // Scan from the highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_any      = 1'b0;
        w_next_idx = '0;
        for (int k = NM - 1; k >= 0; k--) begin
            logic [c_PW-1:0] w_k_idx;
            w_k_idx = c_PW'((int'(r_ptr) + k) % NM);
            if (w_req[w_k_idx]) begin
                w_any      = 1'b1;
                w_next_idx = w_k_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= c_ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_state <= c_ST_BUSY;
                        r_gidx  <= w_next_idx;
                        r_grant <= NM'(1) << w_next_idx;
                    end
                end
                default: begin
                    if (!i_mcyc[r_gidx]) begin
                        r_state <= c_ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= c_PW'((int'(r_gidx) + 1) % NM);
                    end
                end
            endcase
        end
    end

`ifdef WBC_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT + 1);
    logic [c_TW-1:0] r_tcnt;

    assign w_tfire = w_busy & (r_tcnt == c_TW'(TIMEOUT));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tcnt <= '0;
        end else if (w_gstb && !i_sack && !i_serr && !w_tfire) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else begin
            r_tcnt <= '0;
        end
    end
`else
    // TIMEOUT is never negative, so this never fires.
    assign w_tfire = (TIMEOUT < 0);
`endif

    assign o_grant = r_grant;
    assign o_scyc  = w_gcyc;
    assign o_sstb  = w_gstb & ~w_tfire;
    assign o_swe   = i_mwe[r_gidx];
    assign o_saddr = i_maddr[int'(r_gidx)*AW +: AW];
    assign o_sdata = i_mdata[int'(r_gidx)*DW +: DW];
    assign o_ssel  = i_msel[int'(r_gidx)*c_SW +: c_SW];
    assign o_mdata = {NM{i_sdata}};
    assign o_mack  = r_grant & {NM{w_busy & i_sack}};
    assign o_merr  = r_grant & {NM{w_busy & (i_serr | w_tfire)}};

endmodule
`default_nettype wire
